vga_plot_scheduler: RTL and testbench
=====================================

VGA_PLOT_SCHEDULER -- requirements
Module: vga_plot_scheduler

Interface
REQ-001 Parameter LAT, default 2, colour-source latency in cycles from scanX/scanY to scanCol; legal range 1..4.
REQ-002 Parameter XMAX, default 319, last sweep column.
REQ-003 Parameter YMAX, default 239, last sweep row.
REQ-004 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  sweep runs while high.
REQ-007 restart  input  1  one-cycle pulse; returns the sweep to (0,0).
REQ-008 scanX  output  9  sweep column presented to the game renderers.
REQ-009 scanY  output  8  sweep row presented to the game renderers.
REQ-010 scanCol  input  3  renderer colour for the scanX/scanY presented LAT cycles earlier.
REQ-011 reqValid  input  1  overlay point-plot request.
REQ-012 reqX  input  9 / reqY  input  8 / reqCol  input  3  overlay point coordinate and colour.
REQ-013 reqReady  output  1  combinational grant; the request transfers on a cycle where reqValid and reqReady are both high.
REQ-014 plotX  output  9 / plotY  output  8 / plotCol  output  3  registered write to vga_adapter.
REQ-015 plot  output  1  registered write strobe to vga_adapter.
REQ-016 frameDone  output  1  registered one-cycle pulse.

Function
REQ-017 The sweep counter (scanX,scanY) SHALL advance on every cycle with enable=1 and no grant; otherwise it holds.
REQ-018 Sweep order: scanX increments; at scanX=XMAX it wraps to 0 and scanY increments; at (XMAX,YMAX) the counter wraps to (0,0).
REQ-019 restart=1 SHALL load (0,0) on the next edge, override advance and hold, and leave in-flight pipeline entries intact.
REQ-020 Each cycle, one entry SHALL enter a LAT-deep delay line: POINT (captures reqX,reqY,reqCol) if granted; else SWEEP (captures scanX,scanY) if the counter advances; else NONE.
REQ-021 reqReady = reqValid AND NOT (enable=1 AND a grant occurred on the previous cycle); the sweep therefore receives at least one of every two cycles while enabled.
REQ-022 With enable=0, grants SHALL be allowed on every cycle.
REQ-023 An entry entering at cycle t SHALL produce its output at edge t+LAT+1: SWEEP writes (x,y,scanCol sampled at t+LAT) with plot=1; POINT writes (x,y,col) with plot=1; NONE gives plot=0.
REQ-024 Output order SHALL equal entry order; no pixel is dropped, duplicated, or reordered.
REQ-025 POINT entries with reqX>XMAX or reqY>YMAX SHALL be accepted (reqReady=1) but produce plot=0.
REQ-026 When plot=0, plotX/plotY/plotCol SHALL hold their previous values.
REQ-027 frameDone SHALL pulse on the same edge that a SWEEP write to (XMAX,YMAX) is output.
REQ-028 A restart and a grant in the same cycle SHALL both take effect: the POINT entry enters and the counter loads (0,0).

Reset
REQ-029 resetn=0 SHALL immediately clear scanX, scanY, plotX, plotY, and plotCol to 0, clear plot and frameDone to 0, and mark all delay-line entries NONE.
REQ-030 reqReady SHALL be 0 during reset; the previous-grant flag clears to 0.
REQ-031 Reset asserted mid-frame SHALL discard in-flight entries; after release the sweep restarts at (0,0).

Verification
REQ-032 LAT=2, enable=1, scanCol = scanX[2:0] delayed 2 cycles -> plot every cycle from the 3rd edge after release; first write (0,0,0); 76800 writes per frame; frameDone once per frame, coincident with (319,239).
REQ-033 reqValid held high with (5,7,3,) and enable=1 -> reqReady alternates 1,0,1,0; POINT writes of (5,7,3) interleave 1:1 with sweep writes; the sweep still completes every coordinate.
REQ-034 Single grant at sweep position (10,0) -> scanX holds 10 for one cycle; the output stream reads (9,0), then (5,7,3), then (10,0) with no gap in plot.
REQ-035 Request (320,0,7) -> reqReady=1; plot stays 0 in that output slot; plotX/plotY/plotCol unchanged.
REQ-036 enable dropped at (100,50) for 20 cycles, then raised -> no SWEEP writes during the gap; the next sweep write is (100,50); with enable=0 a continuous request is granted every cycle.
REQ-037 restart at (200,120), and separately resetn pulsed low mid-frame -> restart: writes up to (199,120) still emerge, then (0,0). Reset: plot=0 at once; the first write after release is (0,0).

Source files
------------

// File: rtl/vga_plot_scheduler.sv
// Merges a raster sweep with overlay point-plot requests into a single ordered
// pixel-write stream for vga_adapter, aligned to the renderer's colour latency.
module vga_plot_scheduler #(
  parameter int LAT  = 2,
  parameter int XMAX = 319,
  parameter int YMAX = 239
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       enable,
  input  logic       restart,
  output logic [8:0] scanX,
  output logic [7:0] scanY,
  input  logic [2:0] scanCol,
  input  logic       reqValid,
  input  logic [8:0] reqX,
  input  logic [7:0] reqY,
  input  logic [2:0] reqCol,
  output logic       reqReady,
  output logic [8:0] plotX,
  output logic [7:0] plotY,
  output logic [2:0] plotCol,
  output logic       plot,
  output logic       frameDone
);
  typedef enum logic [1:0] {ENT_NONE, ENT_SWEEP, ENT_POINT} entKind_e;

  localparam logic [8:0] XLAST = 9'(XMAX);
  localparam logic [7:0] YLAST = 8'(YMAX);

  logic [8:0] scanX_q, scanX_d;
  logic [7:0] scanY_q, scanY_d;
  logic       prevGrant_q;
  logic       grant;
  logic       advance;

  entKind_e   inKind;
  logic [8:0] inX;
  logic [7:0] inY;
  logic [2:0] inCol;

  entKind_e   kind_q [LAT];
  logic [8:0] x_q    [LAT];
  logic [7:0] y_q    [LAT];
  logic [2:0] col_q  [LAT];

  logic [8:0] plotX_q;
  logic [7:0] plotY_q;
  logic [2:0] plotCol_q;
  logic       plot_q;
  logic       frameDone_q;

  // A grant steals the sweep's slot, so back-to-back grants are refused while
  // sweeping to guarantee the raster at least every other cycle.
  always_comb begin
    reqReady = resetn & reqValid & ~(enable & prevGrant_q);
    grant    = reqReady;
    advance  = enable & ~grant & ~restart;

    scanX_d = scanX_q;
    scanY_d = scanY_q;
    if (restart) begin
      scanX_d = '0;
      scanY_d = '0;
    end else if (advance) begin
      if (scanX_q == XLAST) begin
        scanX_d = '0;
        scanY_d = (scanY_q == YLAST) ? 8'd0 : scanY_q + 8'd1;
      end else begin
        scanX_d = scanX_q + 9'd1;
      end
    end

    // Off-screen points are accepted but travel as empty slots.
    inKind = ENT_NONE;
    inX    = scanX_q;
    inY    = scanY_q;
    inCol  = reqCol;
    if (grant) begin
      inX = reqX;
      inY = reqY;
      if (reqX <= XLAST && reqY <= YLAST) inKind = ENT_POINT;
    end else if (advance) begin
      inKind = ENT_SWEEP;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      scanX_q     <= '0;
      scanY_q     <= '0;
      prevGrant_q <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        kind_q[i] <= ENT_NONE;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        col_q[i]  <= '0;
      end
      plotX_q     <= '0;
      plotY_q     <= '0;
      plotCol_q   <= '0;
      plot_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      scanX_q     <= scanX_d;
      scanY_q     <= scanY_d;
      prevGrant_q <= grant;

      kind_q[0] <= inKind;
      x_q[0]    <= inX;
      y_q[0]    <= inY;
      col_q[0]  <= inCol;
      for (int i = 1; i < LAT; i++) begin
        kind_q[i] <= kind_q[i-1];
        x_q[i]    <= x_q[i-1];
        y_q[i]    <= y_q[i-1];
        col_q[i]  <= col_q[i-1];
      end

      // The oldest sweep entry meets the renderer colour for its coordinate now.
      plot_q      <= 1'b0;
      frameDone_q <= 1'b0;
      case (kind_q[LAT-1])
        ENT_SWEEP: begin
          plot_q      <= 1'b1;
          plotX_q     <= x_q[LAT-1];
          plotY_q     <= y_q[LAT-1];
          plotCol_q   <= scanCol;
          frameDone_q <= (x_q[LAT-1] == XLAST) && (y_q[LAT-1] == YLAST);
        end
        ENT_POINT: begin
          plot_q    <= 1'b1;
          plotX_q   <= x_q[LAT-1];
          plotY_q   <= y_q[LAT-1];
          plotCol_q <= col_q[LAT-1];
        end
        default: begin
        end
      endcase
    end
  end

  assign scanX     = scanX_q;
  assign scanY     = scanY_q;
  assign plotX     = plotX_q;
  assign plotY     = plotY_q;
  assign plotCol   = plotCol_q;
  assign plot      = plot_q;
  assign frameDone = frameDone_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Self-checking bench for vga_plot_scheduler: directed vector table, corner
// sequences, and random traffic against a linear-position reference model.
module tb_vga_plot_scheduler;
  localparam int LAT  = 2;
  localparam int XMAX = 63;
  localparam int YMAX = 47;
  localparam int NPIX = (XMAX + 1) * (YMAX + 1);

  localparam int K_NONE  = 0;
  localparam int K_SWEEP = 1;
  localparam int K_POINT = 2;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       enable   = 1'b0;
  logic       restart  = 1'b0;
  logic       reqValid = 1'b0;
  logic [8:0] reqX     = '0;
  logic [7:0] reqY     = '0;
  logic [2:0] reqCol   = '0;
  logic [2:0] scanCol  = '0;
  logic [2:0] rendStage = '0;
  logic [8:0] scanX;
  logic [7:0] scanY;
  logic       reqReady;
  logic [8:0] plotX;
  logic [7:0] plotY;
  logic [2:0] plotCol;
  logic       plot;
  logic       frameDone;

  vga_plot_scheduler #(.LAT(LAT), .XMAX(XMAX), .YMAX(YMAX)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .enable   (enable),
    .restart  (restart),
    .scanX    (scanX),
    .scanY    (scanY),
    .scanCol  (scanCol),
    .reqValid (reqValid),
    .reqX     (reqX),
    .reqY     (reqY),
    .reqCol   (reqCol),
    .reqReady (reqReady),
    .plotX    (plotX),
    .plotY    (plotY),
    .plotCol  (plotCol),
    .plot     (plot),
    .frameDone(frameDone)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Renderer stand-in: colour = (x ^ y) mod 8, delivered two cycles later.
  always @(posedge CLOCK_50) begin
    rendStage <= 3'(scanX ^ {1'b0, scanY});
    scanCol   <= rendStage;
  end

  typedef struct { int kind; int x; int y; int col; } ent_t;
  typedef struct { int x; int y; int col; } wr_t;
  typedef struct {
    bit en; bit rs; bit vld; int rx; int ry; int rc;
    int expReady; int expScanX; int expPlot; int expX; int expY; int expCol;
  } vec_t;

  ent_t mPipe[$];
  wr_t  writes[$];
  int   mPos, mPlotX, mPlotY, mPlotCol, mPlot, mFrame, mFrames, dutFrames;
  bit   mPrevGrant;
  int   lastReady;
  int   checkCount = 0;
  int   passCount  = 0;

  task automatic checkOutput(input string nm, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d at time %0t", nm, act, exp, $time);
  endtask

  task automatic modelReset();
    ent_t e;
    e = '{K_NONE, 0, 0, 0};
    mPipe.delete();
    for (int i = 0; i < LAT; i++) mPipe.push_back(e);
    mPos = 0; mPlotX = 0; mPlotY = 0; mPlotCol = 0; mPlot = 0; mFrame = 0;
    mPrevGrant = 1'b0;
  endtask

  task automatic modelEdge(input bit en, input bit rs, input bit grant,
                           input int rx, input int ry, input int rc);
    ent_t e, o;
    e = '{K_NONE, 0, 0, 0};
    if (grant) begin
      if (rx <= XMAX && ry <= YMAX) e = '{K_POINT, rx, ry, rc};
    end else if (en && !rs) begin
      e = '{K_SWEEP, mPos % (XMAX + 1), mPos / (XMAX + 1), 0};
      mPos = (mPos + 1) % NPIX;
    end
    if (rs) mPos = 0;
    mPrevGrant = grant;
    o = mPipe.pop_front();
    mPipe.push_back(e);
    mPlot = 0;
    mFrame = 0;
    if (o.kind == K_SWEEP) begin
      mPlot = 1; mPlotX = o.x; mPlotY = o.y; mPlotCol = (o.x ^ o.y) & 7;
      mFrame = (o.x == XMAX && o.y == YMAX) ? 1 : 0;
      mFrames += mFrame;
    end else if (o.kind == K_POINT) begin
      mPlot = 1; mPlotX = o.x; mPlotY = o.y; mPlotCol = o.col;
    end
  endtask

  // Called just after a rising edge; drives one cycle and checks its results.
  task automatic applyStimulus(input bit en, input bit rs, input bit vld,
                               input int rx, input int ry, input int rc);
    bit  expReady;
    wr_t w;
    enable = en; restart = rs; reqValid = vld;
    reqX = 9'(rx); reqY = 8'(ry); reqCol = 3'(rc);
    #1;
    expReady = (resetn === 1'b1) && vld && !(en && mPrevGrant);
    lastReady = int'(reqReady);
    checkOutput("reqReady", lastReady, int'(expReady));
    @(posedge CLOCK_50);
    #1;
    modelEdge(en, rs, expReady, rx, ry, rc);
    checkOutput("plot", int'(plot), mPlot);
    checkOutput("frameDone", int'(frameDone), mFrame);
    checkOutput("plotX", int'(plotX), mPlotX);
    checkOutput("plotY", int'(plotY), mPlotY);
    checkOutput("plotCol", int'(plotCol), mPlotCol);
    checkOutput("scanX", int'(scanX), mPos % (XMAX + 1));
    checkOutput("scanY", int'(scanY), mPos / (XMAX + 1));
    if (plot) begin
      w.x = int'(plotX); w.y = int'(plotY); w.col = int'(plotCol);
      writes.push_back(w);
    end
    if (frameDone) dutFrames++;
  endtask

  task automatic doReset();
    enable = 1'b0; restart = 1'b0; reqValid = 1'b1; reqX = 9'd3; reqY = 8'd4;
    resetn = 1'b0;
    #1;
    checkOutput("rstPlot", int'(plot), 0);
    checkOutput("rstFrameDone", int'(frameDone), 0);
    checkOutput("rstScanX", int'(scanX), 0);
    checkOutput("rstScanY", int'(scanY), 0);
    checkOutput("rstPlotX", int'(plotX), 0);
    checkOutput("rstPlotY", int'(plotY), 0);
    checkOutput("rstPlotCol", int'(plotCol), 0);
    checkOutput("rstReqReady", int'(reqReady), 0);
    modelReset();
    repeat (2) @(posedge CLOCK_50);
    #1;
    reqValid = 1'b0;
    resetn = 1'b1;
  endtask

  task automatic seekTo(input int tx, input int ty);
    int n;
    n = 0;
    while (mPos != ty * (XMAX + 1) + tx && n < NPIX + 16) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
      n++;
    end
    checkOutput("seekReached", mPos, ty * (XMAX + 1) + tx);
  endtask

  task automatic checkWrite(input string nm, input int idx, input int x, input int y, input int col);
    if (idx < writes.size()) begin
      checkOutput({nm, "X"}, writes[idx].x, x);
      checkOutput({nm, "Y"}, writes[idx].y, y);
      checkOutput({nm, "Col"}, writes[idx].col, col);
    end else begin
      checkOutput({nm, "Present"}, writes.size(), idx + 1);
    end
  endtask

  vec_t vecs[14];

  initial begin
    bit en, rs, vld;
    int rx, ry;

    vecs[0]  = '{1,0,0,  0, 0,0,  0,1,0, 0,0,0};
    vecs[1]  = '{1,0,1,  5, 7,3,  1,1,0, 0,0,0};
    vecs[2]  = '{1,0,1,  5, 7,3,  0,2,1, 0,0,0};
    vecs[3]  = '{1,0,1,  5, 7,3,  1,2,1, 5,7,3};
    vecs[4]  = '{1,0,0,  0, 0,0,  0,3,1, 1,0,1};
    vecs[5]  = '{0,0,1, 40, 9,6,  1,3,1, 5,7,3};
    vecs[6]  = '{0,0,1, 64, 0,7,  1,3,1, 2,0,2};
    vecs[7]  = '{0,0,0,  0, 0,0,  0,3,1, 40,9,6};
    vecs[8]  = '{0,0,0,  0, 0,0,  0,3,0, 40,9,6};
    vecs[9]  = '{1,1,0,  0, 0,0,  0,0,0, 40,9,6};
    vecs[10] = '{1,0,0,  0, 0,0,  0,1,0, 40,9,6};
    vecs[11] = '{1,1,1,  0,47,1,  1,0,0, 40,9,6};
    vecs[12] = '{1,0,0,  0, 0,0,  0,1,1, 0,0,0};
    vecs[13] = '{1,0,0,  0, 0,0,  0,2,1, 0,47,1};

    mFrames = 0; dutFrames = 0;
    modelReset();
    @(posedge CLOCK_50);
    #1;
    doReset();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].en, vecs[i].rs, vecs[i].vld, vecs[i].rx, vecs[i].ry, vecs[i].rc);
      checkOutput($sformatf("vec%0dReady", i), lastReady, vecs[i].expReady);
      checkOutput($sformatf("vec%0dScanX", i), int'(scanX), vecs[i].expScanX);
      checkOutput($sformatf("vec%0dPlot", i), int'(plot), vecs[i].expPlot);
      checkOutput($sformatf("vec%0dPlotX", i), int'(plotX), vecs[i].expX);
      checkOutput($sformatf("vec%0dPlotY", i), int'(plotY), vecs[i].expY);
      checkOutput($sformatf("vec%0dPlotCol", i), int'(plotCol), vecs[i].expCol);
    end

    // Held request while sweeping: grant alternates.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 5, 7, 3);
      checkOutput("altReady", lastReady, (i % 2 == 0) ? 1 : 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);

    // Single grant inserted at (10,0).
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0);
    seekTo(10, 0);
    writes.delete();
    applyStimulus(1'b1, 1'b0, 1'b1, 5, 7, 3);
    checkOutput("grantHoldX", int'(scanX), 10);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("insertCount", writes.size(), 4);
    checkWrite("insertPrev", 1, 9, 0, 1);
    checkWrite("insertPoint", 2, 5, 7, 3);
    checkWrite("insertNext", 3, 10, 0, 2);

    // Enable gap with a continuous request.
    seekTo(30, 20);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1, 1, 5);
      checkOutput("gapReady", lastReady, 1);
    end
    writes.delete();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("gapCount", writes.size(), 3);
    checkWrite("gapPoint", 0, 1, 1, 5);
    checkWrite("gapResume", 2, 30, 20, 2);

    // Restart keeps in-flight writes.
    seekTo(40, 30);
    writes.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 0, 0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("restartCount", writes.size(), 3);
    checkWrite("restartTail", 1, 39, 30, (39 ^ 30) & 7);
    checkWrite("restartHead", 2, 0, 0, 0);

    // Reset mid-frame discards in-flight writes.
    seekTo(20, 10);
    doReset();
    writes.delete();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    checkOutput("postRstCount", writes.size(), 1);
    checkWrite("postRstFirst", 0, 0, 0, 0);

    // Random traffic; restarts and a reset only late so full frames complete.
    for (int i = 0; i < 10000; i++) begin
      en  = ($urandom_range(0, 31) != 0);
      vld = ($urandom_range(0, 9) < 2);
      rs  = (i > 8000) && ($urandom_range(0, 399) == 0);
      rx  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(XMAX + 1, 511)) : int'($urandom_range(0, XMAX));
      ry  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(YMAX + 1, 255)) : int'($urandom_range(0, YMAX));
      if (i == 9000) doReset();
      applyStimulus(en, rs, vld, rx, ry, int'($urandom_range(0, 7)));
    end
    checkOutput("frameCount", dutFrames, mFrames);
    checkOutput("framesSeen", (dutFrames > 0) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
